div_ratio_meter: RTL

DIV_RATIO_METER -- requirements
Module: div_ratio_meter

---
 rtl/div_meter_pkg.sv | 13 +
 rtl/sync_ff.sv | 26 ++
 rtl/div_ratio_meter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/div_meter_pkg.sv
// Shared types and default sizing for the divided-clock ratio meter.
package div_meter_pkg;

   localparam int unsigned CNT_W_DEFAULT       = 16;
   localparam int unsigned SYNC_STAGES_DEFAULT = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } meter_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit (DEPTH >= 2).
module sync_ff
   import div_meter_pkg::*;
#(
   parameter int unsigned DEPTH = SYNC_STAGES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] stages;

   // Shift the asynchronous input through DEPTH flops
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stages <= '0;
      end else begin
         stages <= {stages[DEPTH-2:0], d};
      end
   end

   assign q = stages[DEPTH-1];

endmodule

// File: rtl/div_ratio_meter.sv
// Measures period and high time of a divided clock in clk cycles.
// Optional lock detection is compiled in with DIV_RATIO_METER_LOCK_EN.
module div_ratio_meter
   import div_meter_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEFAULT,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_in,
   input  logic             clr,
   output logic [CNT_W-1:0] ratio,
   output logic [CNT_W-1:0] high_cnt,
   output logic             valid,
   output logic             overflow,
   output logic             locked
);

   meter_state_t     state;
   logic             div_sync;
   logic             div_d;
   logic             rise;
   logic             fall;
   logic [CNT_W-1:0] period_cnt;
   logic [CNT_W-1:0] high_run;
   logic [CNT_W-1:0] high_lat;
   logic             period_full;

   sync_ff #(
      .DEPTH (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (div_in),
      .q   (div_sync)
   );

   // Edge-detect flop on the synchronized input
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_d <= 1'b0;
      end else begin
         div_d <= div_sync;
      end
   end

   assign rise        = div_sync & ~div_d;
   assign fall        = ~div_sync & div_d;
   assign period_full = (period_cnt == '1);

   // Measurement FSM with registered results; clr outranks edges and overflow
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         period_cnt <= '0;
         high_run   <= '0;
         high_lat   <= '0;
         ratio      <= '0;
         high_cnt   <= '0;
         valid      <= 1'b0;
         overflow   <= 1'b0;
`ifdef DIV_RATIO_METER_LOCK_EN
         locked     <= 1'b0;
`endif
      end else if (clr) begin
         state      <= IDLE;
         period_cnt <= '0;
         high_run   <= '0;
         high_lat   <= '0;
         ratio      <= '0;
         high_cnt   <= '0;
         valid      <= 1'b0;
         overflow   <= 1'b0;
`ifdef DIV_RATIO_METER_LOCK_EN
         locked     <= 1'b0;
`endif
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               // Arm on the first rising edge; no result yet
               if (rise) begin
                  state      <= HIGH;
                  period_cnt <= CNT_W'(1);
                  high_run   <= CNT_W'(1);
               end
            end
            HIGH: begin
               // A rise here cannot follow a detected fall, so it is ignored
               if (period_full) begin
                  state      <= IDLE;
                  overflow   <= 1'b1;
                  period_cnt <= '0;
                  high_run   <= '0;
`ifdef DIV_RATIO_METER_LOCK_EN
                  locked     <= 1'b0;
`endif
               end else begin
                  period_cnt <= period_cnt + CNT_W'(1);
                  if (fall) begin
                     high_lat <= high_run;
                     state    <= LOW;
                  end else begin
                     high_run <= high_run + CNT_W'(1);
                  end
               end
            end
            LOW: begin
               if (rise) begin
                  ratio      <= period_cnt;
                  high_cnt   <= high_lat;
                  valid      <= 1'b1;
`ifdef DIV_RATIO_METER_LOCK_EN
                  // Outputs still hold the previous valid's values here
                  locked     <= (period_cnt == ratio) && (high_lat == high_cnt);
`endif
                  period_cnt <= CNT_W'(1);
                  high_run   <= CNT_W'(1);
                  state      <= HIGH;
               end else if (period_full) begin
                  state      <= IDLE;
                  overflow   <= 1'b1;
                  period_cnt <= '0;
                  high_run   <= '0;
`ifdef DIV_RATIO_METER_LOCK_EN
                  locked     <= 1'b0;
`endif
               end else begin
                  period_cnt <= period_cnt + CNT_W'(1);
               end
            end
            default: begin
               state      <= IDLE;
               period_cnt <= '0;
               high_run   <= '0;
            end
         endcase
      end
   end

`ifndef DIV_RATIO_METER_LOCK_EN
   assign locked = 1'b0;
`endif

endmodule
